// File: rtl/ctrl_pkt_parser_pkg.sv
// Shared definitions for the control-plane packet parser.
//   - Header opcodes and header field offsets
//   - Parser FSM state encoding
//   - Width of the optional statistics counters
//   - load_len(): payload length of a LOAD packet from its header counts
package acis_parser_pkg;

  localparam logic [7:0] OPC_LOAD   = 8'hC1;
  localparam logic [7:0] OPC_STREAM = 8'hD1;

  localparam int OPC_W       = 8;   // opcode sits in the top byte of the phit
  localparam int NINB_LSB    = 0;
  localparam int NCFG_LSB    = 8;
  localparam int NSTREAM_LSB = 16;
  localparam int CNT_W       = 8;   // width of ncfg / ninb header fields
  localparam int LEN_W       = 16;  // packet length / beat counter width
  localparam int STATS_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LD_PULSE,
    LD_GAP,
    LOAD,
    STREAM,
    DRAIN
  } state_t;

  // Every config entry is loaded once per stage plus once for the state
  // table, followed by the inbound buffer entries.
  function automatic logic [LEN_W-1:0] load_len(input logic [CNT_W-1:0] ncfg,
                                                input logic [CNT_W-1:0] ninb,
                                                input int unsigned      num_stage);
    return LEN_W'(ncfg) * LEN_W'(num_stage + 1) + LEN_W'(ninb);
  endfunction

endpackage

// File: rtl/ctrl_pkt_parser_stats.sv
// Packet statistics counters for ctrl_pkt_parser.
// Only present when PARSER_STATS_EN is defined.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   ev_load, ev_stream, ev_err     one-cycle event strobes from the parser
//   pkt_load_cnt                   completed LOAD packets (wraps at 2^32)
//   pkt_stream_cnt                 completed STREAM packets (wraps at 2^32)
//   pkt_err_cnt                    aborted / malformed packets (wraps at 2^32)
`ifdef PARSER_STATS_EN
module ctrl_pkt_parser_stats
  import acis_parser_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ev_load,
  input  logic               ev_stream,
  input  logic               ev_err,
  output logic [STATS_W-1:0] pkt_load_cnt,
  output logic [STATS_W-1:0] pkt_stream_cnt,
  output logic [STATS_W-1:0] pkt_err_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_load_cnt   <= '0;
      pkt_stream_cnt <= '0;
      pkt_err_cnt    <= '0;
    end else begin
      if (ev_load)   pkt_load_cnt   <= pkt_load_cnt + STATS_W'(1);
      if (ev_stream) pkt_stream_cnt <= pkt_stream_cnt + STATS_W'(1);
      if (ev_err)    pkt_err_cnt    <= pkt_err_cnt + STATS_W'(1);
    end
  end

endmodule
`endif

// File: rtl/ctrl_pkt_parser.sv
// Front end of control_plane: parses a phit stream into loader and
// stream-in sequencing.
//   LOAD packets   -> start_loader pulse, then one wr_data phit per cycle.
//   STREAM packets -> stream_in beats under ready_stream_in backpressure,
//                     framed by start_stream_in.
// Optional feature macro: PARSER_STATS_EN adds pkt_load_cnt, pkt_stream_cnt
// and pkt_err_cnt (ctrl_pkt_parser_stats).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast  inbound phit stream; s_tready back to source
//   start_loader              one-cycle load start pulse
//   wr_data                   load phit, zero when no load phit is carried
//   num_entry_config_table    ncfg of the last accepted LOAD header
//   num_entry_inbound         ninb of the last accepted LOAD header
//   start_stream_in           high through the STREAM phase
//   stream_in/stream_in_valid forwarded stream beat
//   ready_stream_in           backpressure from control_plane
//   busy                      parser not idle
//   err_hdr/err_len/err_underrun  sticky error flags
module ctrl_pkt_parser
  import acis_parser_pkg::*;
#(
  parameter int PHIT_SIZE    = 512,
  parameter int DWIDTH_RFADD = 8,
  parameter int NUM_STAGE    = 6,
  parameter int LOAD_GAP     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PHIT_SIZE-1:0]    s_tdata,
  input  logic                    s_tvalid,
  input  logic                    s_tlast,
  output logic                    s_tready,
  output logic                    start_loader,
  output logic [PHIT_SIZE-1:0]    wr_data,
  output logic [DWIDTH_RFADD-1:0] num_entry_config_table,
  output logic [DWIDTH_RFADD-1:0] num_entry_inbound,
  output logic                    start_stream_in,
  output logic [PHIT_SIZE-1:0]    stream_in,
  output logic                    stream_in_valid,
  input  logic                    ready_stream_in,
  output logic                    busy,
  output logic                    err_hdr,
  output logic                    err_len,
  output logic                    err_underrun
`ifdef PARSER_STATS_EN
  ,
  output logic [STATS_W-1:0]      pkt_load_cnt,
  output logic [STATS_W-1:0]      pkt_stream_cnt,
  output logic [STATS_W-1:0]      pkt_err_cnt
`endif
);

  state_t           state;
  logic [LEN_W-1:0] pkt_len;
  logic [LEN_W-1:0] beat_cnt;
  logic [7:0]       gap_cnt;

  logic [OPC_W-1:0] hdr_opc;
  logic [LEN_W-1:0] hdr_ld_len;
  logic [LEN_W-1:0] hdr_st_len;
  logic             hdr_is_load;
  logic             hdr_is_stream;
  logic             hdr_bad;
  logic             beat;
  logic             at_last;

  // Header decode and payload beat qualification
  always_comb begin
    hdr_opc       = s_tdata[PHIT_SIZE-1 -: OPC_W];
    hdr_ld_len    = load_len(s_tdata[NCFG_LSB +: CNT_W], s_tdata[NINB_LSB +: CNT_W], NUM_STAGE);
    hdr_st_len    = s_tdata[NSTREAM_LSB +: LEN_W];
    hdr_is_load   = (hdr_opc == OPC_LOAD)   && (hdr_ld_len != '0);
    hdr_is_stream = (hdr_opc == OPC_STREAM) && (hdr_st_len != '0);
    hdr_bad       = !(hdr_is_load || hdr_is_stream);
    beat          = ((state == LOAD) && s_tvalid) ||
                    ((state == STREAM) && s_tvalid && ready_stream_in);
    at_last       = (beat_cnt == pkt_len - LEN_W'(1));
  end

  always_comb begin
    s_tready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE, LOAD, DRAIN: s_tready = 1'b1;
        STREAM:            s_tready = ready_stream_in;
        default:           s_tready = 1'b0;
      endcase
    end
  end

  assign busy = (state != IDLE);

  // Stage p0 -> p1: parser FSM; every output below is registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state                  <= IDLE;
      pkt_len                <= '0;
      beat_cnt               <= '0;
      gap_cnt                <= '0;
      start_loader           <= 1'b0;
      wr_data                <= '0;
      num_entry_config_table <= '0;
      num_entry_inbound      <= '0;
      start_stream_in        <= 1'b0;
      stream_in              <= '0;
      stream_in_valid        <= 1'b0;
      err_hdr                <= 1'b0;
      err_len                <= 1'b0;
      err_underrun           <= 1'b0;
    end else begin
      start_loader    <= 1'b0;
      wr_data         <= '0;
      stream_in       <= '0;
      stream_in_valid <= 1'b0;
      // Held while in STREAM, so it stays high for the cycle that carries
      // the final registered beat and drops the cycle after.
      start_stream_in <= (state == STREAM);

      case (state)
        IDLE: begin
          if (s_tvalid) begin
            if (hdr_bad) begin
              err_hdr <= 1'b1;
              state   <= s_tlast ? IDLE : DRAIN;
            end else if (s_tlast) begin
              err_len <= 1'b1;
              state   <= IDLE;
            end else if (hdr_is_load) begin
              num_entry_config_table <= s_tdata[NCFG_LSB +: DWIDTH_RFADD];
              num_entry_inbound      <= s_tdata[NINB_LSB +: DWIDTH_RFADD];
              pkt_len                <= hdr_ld_len;
              beat_cnt               <= '0;
              start_loader           <= 1'b1;
              state                  <= LD_PULSE;
            end else begin
              pkt_len         <= hdr_st_len;
              beat_cnt        <= '0;
              start_stream_in <= 1'b1;
              state           <= STREAM;
            end
          end
        end
        // The wr_data register supplies one of the idle cycles between the
        // pulse and the first load phit, so the stall is one cycle shorter.
        LD_PULSE: begin
          if (LOAD_GAP > 1) begin
            gap_cnt <= 8'(LOAD_GAP - 2);
            state   <= LD_GAP;
          end else begin
            state <= LOAD;
          end
        end
        LD_GAP: begin
          if (gap_cnt == 8'd0) state <= LOAD;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        LOAD: begin
          if (!s_tvalid) begin
            err_underrun <= 1'b1;
            state        <= DRAIN;
          end else begin
            wr_data <= s_tdata;
          end
        end
        STREAM: begin
          if (beat) begin
            stream_in       <= s_tdata;
            stream_in_valid <= 1'b1;
          end
        end
        DRAIN: begin
          if (s_tvalid && s_tlast) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Shared length/tlast bookkeeping for LOAD and STREAM payload beats
      if (beat) begin
        if (at_last) begin
          if (!s_tlast) err_len <= 1'b1;
          state <= s_tlast ? IDLE : DRAIN;
        end else if (s_tlast) begin
          err_len <= 1'b1;
          state   <= IDLE;
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
    end
  end

`ifdef PARSER_STATS_EN
  logic ev_load;
  logic ev_stream;
  logic ev_err;

  assign ev_load   = (state == LOAD)   && beat && at_last && s_tlast;
  assign ev_stream = (state == STREAM) && beat && at_last && s_tlast;
  assign ev_err    = ((state == IDLE) && s_tvalid && (hdr_bad || s_tlast)) ||
                     ((state == LOAD) && !s_tvalid) ||
                     (beat && (at_last != s_tlast));

  ctrl_pkt_parser_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .ev_load        (ev_load),
    .ev_stream      (ev_stream),
    .ev_err         (ev_err),
    .pkt_load_cnt   (pkt_load_cnt),
    .pkt_stream_cnt (pkt_stream_cnt),
    .pkt_err_cnt    (pkt_err_cnt)
  );
`endif

endmodule

// File: tb/tb_ctrl_pkt_parser.sv
// Bench for ctrl_pkt_parser: directed LOAD/STREAM/error packets, a queue
// scoreboard of the phits each packet must deliver, and cycle-position
// checks for start_loader, wr_data and start_stream_in.
// With PARSER_STATS_EN defined the statistics counters are checked too.
module tb_ctrl_pkt_parser;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [511:0] s_tdata = '0;
  logic         s_tvalid = 1'b0;
  logic         s_tlast = 1'b0;
  logic         s_tready;
  logic         start_loader;
  logic [511:0] wr_data;
  logic [7:0]   num_entry_config_table;
  logic [7:0]   num_entry_inbound;
  logic         start_stream_in;
  logic [511:0] stream_in;
  logic         stream_in_valid;
  logic         ready_stream_in = 1'b1;
  logic         busy;
  logic         err_hdr, err_len, err_underrun;
`ifdef PARSER_STATS_EN
  logic [31:0]  pkt_load_cnt, pkt_stream_cnt, pkt_err_cnt;
`endif

  ctrl_pkt_parser dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_tdata                (s_tdata),
    .s_tvalid               (s_tvalid),
    .s_tlast                (s_tlast),
    .s_tready               (s_tready),
    .start_loader           (start_loader),
    .wr_data                (wr_data),
    .num_entry_config_table (num_entry_config_table),
    .num_entry_inbound      (num_entry_inbound),
    .start_stream_in        (start_stream_in),
    .stream_in              (stream_in),
    .stream_in_valid        (stream_in_valid),
    .ready_stream_in        (ready_stream_in),
    .busy                   (busy),
    .err_hdr                (err_hdr),
    .err_len                (err_len),
    .err_underrun           (err_underrun)
`ifdef PARSER_STATS_EN
    ,
    .pkt_load_cnt           (pkt_load_cnt),
    .pkt_stream_cnt         (pkt_stream_cnt),
    .pkt_err_cnt            (pkt_err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ready_stream_in: constant 1, or alternating 1/0 every cycle
  bit ready_toggle = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ready_toggle) ready_stream_in = ~ready_stream_in;
    else              ready_stream_in = 1'b1;
  end

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: phits that must appear on wr_data / stream_in, in order
  logic [511:0] exp_wr[$];
  logic [511:0] exp_st[$];
  int n_pulse = 0, pulse_cyc = -1;
  int first_wr = -1, last_wr = -1;
  int ssi_rises = 0, ssi_first = -1, ssi_last = -1, last_st = -1;
  bit ssi_prev = 1'b0;

  always @(negedge clk) begin
    if (wr_data !== '0) begin
      chk("wr_data", wr_data, (exp_wr.size() != 0) ? exp_wr.pop_front() : '0);
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
    end
    if (start_loader) begin
      n_pulse++;
      pulse_cyc = cyc;
    end
    if (stream_in_valid) begin
      chk("stream_in", stream_in, (exp_st.size() != 0) ? exp_st.pop_front() : '0);
      chk("ssi_brackets_beat", start_stream_in, 1);
      last_st = cyc;
    end
    if (start_stream_in && !ssi_prev) begin
      ssi_rises++;
      ssi_first = cyc;
    end
    if (start_stream_in) ssi_last = cyc;
    ssi_prev = start_stream_in;
  end

  function automatic logic [511:0] mk(input int tag, input int k);
    return {16{32'(tag * 1024 + k + 1)}};
  endfunction

  function automatic logic [511:0] hdr(input logic [7:0] opc, input logic [7:0] ncfg,
                                       input logic [7:0] ninb, input logic [15:0] ns);
    logic [511:0] h;
    h = '0;
    h[511:504] = opc;
    h[15:8]    = ncfg;
    h[7:0]     = ninb;
    h[31:16]   = ns;
    return h;
  endfunction

  // Payload length of a LOAD header: state table + 6 stage tables of ncfg
  // entries each, then ninb inbound entries.
  function automatic int ld_len(input int ncfg, input int ninb);
    return 7 * ncfg + ninb;
  endfunction

  int hdr_acc = 0, last_acc = 0;

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic put(input logic [511:0] d, input bit last, output int acc);
    bit rdy;
    int n;
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last;
    n = 0; rdy = 1'b0; acc = -1;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = s_tready;
      if (rdy) acc = cyc;
      @(posedge clk); #1;
      n++;
    end
    if (!rdy) begin
      checks++; failures++;
      $display("FAIL handshake_timeout act=no_ready exp=ready (cycle %0d)", cyc);
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [511:0] h, input int tag, input int n,
                          input int tlast_idx, input int bubble_idx);
    put(h, 1'b0, hdr_acc);
    for (int k = 0; k < n; k++) begin
      if (k == bubble_idx) idle(1);
      put(mk(tag, k), (k == tlast_idx), last_acc);
    end
  endtask

  task automatic check_errs(input bit eh, input bit el, input bit eu);
    chk("err_hdr", err_hdr, eh);
    chk("err_len", err_len, el);
    chk("err_underrun", err_underrun, eu);
  endtask

  task automatic do_reset();
    rst = 1'b1; s_tvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_start_loader", start_loader, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_ncfg", num_entry_config_table, 0);
    chk("rst_ninb", num_entry_inbound, 0);
    chk("rst_start_stream_in", start_stream_in, 0);
    chk("rst_stream_in", stream_in, 0);
    chk("rst_stream_in_valid", stream_in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_errs", {err_hdr, err_len, err_underrun}, 0);
`ifdef PARSER_STATS_EN
    chk("rst_stats", {pkt_load_cnt, pkt_stream_cnt, pkt_err_cnt}, 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic push_load(input int tag, input int n);
    for (int k = 0; k < n; k++) exp_wr.push_back(mk(tag, k));
  endtask

  task automatic push_stream(input int tag, input int n);
    for (int k = 0; k < n; k++) exp_st.push_back(mk(tag, k));
  endtask

  task automatic legal_load(input int tag);
    int np;
    np = n_pulse;
    first_wr = -1;
    push_load(tag, ld_len(2, 16));
    send_pkt(hdr(8'hC1, 8'd2, 8'd16, 16'd0), tag, ld_len(2, 16), ld_len(2, 16) - 1, -1);
    idle(4);
    chk("load_pulses", n_pulse - np, 1);
    chk("pulse_after_hdr", pulse_cyc, hdr_acc + 1);
    chk("first_wr_at_T+3", first_wr - pulse_cyc, 3);
    chk("wr_span_30", last_wr - first_wr, 29);
    chk("load_all_phits", exp_wr.size(), 0);
    chk("ncfg", num_entry_config_table, 2);
    chk("ninb", num_entry_inbound, 16);
    chk("load_idle", busy, 0);
  endtask

  task automatic legal_stream(input int tag, input int n, input bit toggle);
    int nr;
    nr = ssi_rises;
    ready_toggle = toggle;
    push_stream(tag, n);
    send_pkt(hdr(8'hD1, 8'd0, 8'd0, 16'(n)), tag, n, n - 1, -1);
    ready_toggle = 1'b0;
    idle(4);
    chk("stream_all_beats", exp_st.size(), 0);
    chk("ssi_one_frame", ssi_rises - nr, 1);
    chk("ssi_first", ssi_first, hdr_acc + 1);
    chk("ssi_last", ssi_last, last_st);
    chk("stream_idle", busy, 0);
  endtask

`ifdef PARSER_STATS_EN
  task automatic check_stats(input int l, input int s, input int e);
    chk("pkt_load_cnt", pkt_load_cnt, l);
    chk("pkt_stream_cnt", pkt_stream_cnt, s);
    chk("pkt_err_cnt", pkt_err_cnt, e);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int np, nr;
    do_reset();

    // Legal LOAD ncfg=2 ninb=16 (30 phits)
    nr = ssi_rises;
    legal_load(1);
    chk("load_no_stream", ssi_rises - nr, 0);
    check_errs(0, 0, 0);

    // Legal STREAM of 16 beats under toggling backpressure
    legal_stream(2, 16, 1'b1);
    check_errs(0, 0, 0);

    // Underrun: valid drops before phit 10, rest drained, next packet OK
    push_load(3, 10);
    send_pkt(hdr(8'hC1, 8'd2, 8'd16, 16'd0), 3, 30, 29, 10);
    idle(4);
    chk("underrun_phits", exp_wr.size(), 0);
    chk("underrun_idle", busy, 0);
    check_errs(0, 0, 1);
    legal_stream(4, 3, 1'b0);
    check_errs(0, 0, 1);
`ifdef PARSER_STATS_EN
    check_stats(1, 2, 1);
`endif

    // Unknown opcode: flagged, drained, nothing started
    do_reset();
    np = n_pulse; nr = ssi_rises;
    send_pkt(hdr(8'h00, 8'd2, 8'd16, 16'd4), 5, 4, 3, -1);
    idle(4);
    chk("badop_no_pulse", n_pulse - np, 0);
    chk("badop_no_stream", ssi_rises - nr, 0);
    chk("badop_idle", busy, 0);
    check_errs(1, 0, 0);

    // Early tlast at phit 20 of 30: straight back to IDLE
    do_reset();
    push_load(6, 20);
    send_pkt(hdr(8'hC1, 8'd2, 8'd16, 16'd0), 6, 20, 19, -1);
    @(negedge clk);
    chk("early_tlast_idle", busy, 0);
    @(posedge clk); #1;
    legal_stream(7, 2, 1'b0);
    chk("early_tlast_phits", exp_wr.size(), 0);
    check_errs(0, 1, 0);

    // Missing tlast on phit 30: DRAIN until the later tlast
    do_reset();
    push_load(8, 30);
    send_pkt(hdr(8'hC1, 8'd2, 8'd16, 16'd0), 8, 30, -1, -1);
    @(negedge clk);
    chk("no_tlast_drain", busy, 1);
    @(posedge clk); #1;
    put(mk(9, 0), 1'b0, last_acc);
    put(mk(9, 1), 1'b1, last_acc);
    idle(4);
    chk("no_tlast_phits", exp_wr.size(), 0);
    chk("no_tlast_idle", busy, 0);
    check_errs(0, 1, 0);

    // Reset in the middle of a LOAD, then a clean LOAD
    do_reset();
    push_load(10, 10);
    send_pkt(hdr(8'hC1, 8'd2, 8'd16, 16'd0), 10, 10, -1, -1);
    do_reset();
    chk("midrst_phits", exp_wr.size(), 0);
    legal_load(11);
    check_errs(0, 0, 0);
`ifdef PARSER_STATS_EN
    check_stats(1, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
